apb_master: RTL
===============

# apb_master

APB requester that bridges the RV32I core's simple load/store request port onto the peripheral bus. Decodes the target address into one PSEL line per peripheral slot and runs the SETUP/ACCESS sequence. Holds the transfer until the selected slave asserts PREADY, then returns read data and a one-cycle completion pulse to the core. Sits between the core's data-bus decoder and all APB peripherals (GPO, GPI, UART, timer, ...).

## Interface
- NUM_SLAVES, 4, number of peripheral slots (1..16)
- BASE_ADDR, 32'h1000_0000, base of peripheral window; slot n occupies BASE_ADDR + n*0x1000 .. +0xFFF
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit (used only with APB_TIMEOUT_EN)

Ports:
- PCLK  in  1  single clock, all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- req  in  1  core transfer request (level; sampled only in IDLE)
- write  in  1  1 = write, 0 = read
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  qualifies ready: unmapped address (or timeout)
- PADDR  out  32  APB address (full latched addr)
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB access phase
- PWDATA  out  32  APB write data
- PSEL  out  NUM_SLAVES  one-hot slave select
- PRDATA  in  32*NUM_SLAVES  slave read data, slot n at [32n+31:32n]
- PREADY  in  NUM_SLAVES  slave ready, slot n at bit n

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if req=1, latch addr/write/wdata into PADDR/PWRITE/PWDATA and decode the slot.
  - Mapped (addr[31:12] - BASE_ADDR[31:12] < NUM_SLAVES): go to SETUP.
  - Unmapped: go to DONE with err=1 and rdata=0; no PSEL is asserted.
- SETUP: PSEL[slot]=1, PENABLE=0; unconditionally go to ACCESS.
- ACCESS: PSEL[slot]=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
  - Advances only when PREADY[slot]=1: capture PRDATA[slot] into rdata (reads only; writes leave rdata=0), drop PSEL/PENABLE, go to DONE.
  - PREADY bits of unselected slots are ignored.
- DONE: ready=1 for exactly one cycle, err as determined; return to IDLE.
- req is ignored outside IDLE. A req held high in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
- All outputs are registered.

## Timing
- Reset values: rdata=0, ready=0, err=0, PADDR=0, PWRITE=0, PENABLE=0, PWDATA=0, PSEL=0; state=IDLE.
- PRESET asserted mid-transfer: on that edge the FSM returns to IDLE and all outputs take their reset values. No ready is produced for the aborted transfer.
- Cycle numbering for a mapped transfer (cycle 0 = IDLE cycle with req=1):
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS starts.
  - If PREADY[slot] is high in cycle k (k≥2), DONE/ready occurs in cycle k+1.
  - Zero-wait slave: ready in cycle 3. A slave that registers PREADY after PSEL&&PENABLE: ready in cycle 4.
- Unmapped transfer: ready/err in cycle 1.
- Minimum request-to-request spacing: 4 cycles for zero-wait slaves.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without PREADY.
  - When the count reaches TIMEOUT_CYCLES, drop PSEL/PENABLE and go to DONE with err=1 and rdata=32'hDEAD_BEEF.
  - A PREADY arriving in the same cycle the count reaches TIMEOUT_CYCLES wins: normal completion, err=0.
- APB_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely for PREADY; err is raised only for unmapped addresses.

## Test plan
- Write, zero-wait slot 0: req, write=1, addr=0x1000_0004, wdata=0x0000_00A5 -> PSEL=4'b0001 in cycles 1–2, PENABLE only in cycle 2, PADDR/PWDATA stable, ready=1/err=0 in cycle 3.
- Read, slot 2, slave asserts PREADY in cycle 5 with PRDATA=0x1234_5678 -> PSEL=4'b0100 held cycles 1–5, ready=1 and rdata=0x1234_5678 in cycle 6, PSEL=0 in cycle 6.
- Unmapped read addr=0x2000_0000 -> PSEL stays 0, ready=1, err=1, rdata=0 in cycle 1.
- Reset in ACCESS (PRESET high in cycle 2) -> cycle 3 shows PSEL=0, PENABLE=0, ready=0, and no ready follows. Next req after reset completes normally.
- Back-to-back: req held high continuously with two writes to slots 0 and 3 -> second SETUP begins exactly 4 cycles after the first. Noise on unselected PREADY bits has no effect.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=16), PREADY never asserted -> ready=1, err=1, rdata=0xDEAD_BEEF in cycle 19. With the macro undefined, the FSM is still in ACCESS at cycle 100.

Source files
------------

// File: rtl/apb_master.sv
// APB requester bridging the core load/store port onto the peripheral bus.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     req,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [31:0]              PWDATA,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY
);

  localparam int unsigned SLOT_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [19:0] BASE_PAGE = BASE_ADDR[31:12];
  localparam logic [31:0] TMO_DATA  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [SLOT_W-1:0]     slot_dec;
  logic [19:0]           page_off;
  logic                  mapped;
  logic [31:0]           prdata_sel;
  logic                  pready_sel;

  logic [31:0]           paddr_d, pwdata_d, rdata_d;
  logic                  pwrite_d, penable_d, ready_d, err_d;
  logic [NUM_SLAVES-1:0] psel_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Page offset from the window base; wraps for addresses below the base so they fall out of range.
  always_comb begin
    page_off = addr[31:12] - BASE_PAGE;
    mapped   = (page_off < 20'(NUM_SLAVES));
    slot_dec = SLOT_W'(page_off);
  end

  // Response mux for the latched slot; other slots' PREADY/PRDATA never reach the FSM.
  always_comb begin
    prdata_sel = '0;
    pready_sel = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        prdata_sel = PRDATA[32*i +: 32];
        pready_sel = PREADY[i];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    paddr_d   = PADDR;
    pwrite_d  = PWRITE;
    pwdata_d  = PWDATA;
    psel_d    = '0;
    penable_d = 1'b0;
    rdata_d   = '0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          paddr_d  = addr;
          pwrite_d = write;
          pwdata_d = wdata;
          if (mapped) begin
            slot_d  = slot_dec;
            psel_d  = NUM_SLAVES'(1) << slot_dec;
            state_d = S_SETUP;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_SETUP: begin
        psel_d    = PSEL;
        penable_d = 1'b1;
        state_d   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      S_ACCESS: begin
        if (pready_sel) begin
          rdata_d = PWRITE ? 32'h0 : prdata_sel;
          ready_d = 1'b1;
          state_d = S_DONE;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rdata_d = TMO_DATA;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          psel_d    = PSEL;
          penable_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
`else
        else begin
          psel_d    = PSEL;
          penable_d = 1'b1;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      PADDR   <= paddr_d;
      PWRITE  <= pwrite_d;
      PWDATA  <= pwdata_d;
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      rdata   <= rdata_d;
      ready   <= ready_d;
      err     <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
